// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package rv32i_fetch_pkg;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'd0,
        PC_TGT  = 2'd1,
        PC_JALR = 2'd2,
        PC_RSVD = 2'd3
    } pc_sel_e;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage signal bundle between control unit / ROM and the fetch unit.
interface instr_fetch_unit_if;
    logic        fetch_en;
    logic        pc_update;
    logic [1:0]  pc_sel;
    logic [31:0] pc_target;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic [31:0] ir_pc_plus4;
    logic        ir_valid;
    logic        misalign_err;
    logic        range_err;
    logic [31:0] retired_cnt;

    modport master (
        output fetch_en, pc_update, pc_sel, pc_target, instr_data,
        input  instr_addr, ir, ir_pc, ir_pc_plus4, ir_valid,
               misalign_err, range_err, retired_cnt
    );

    modport slave (
        input  fetch_en, pc_update, pc_sel, pc_target, instr_data,
        output instr_addr, ir, ir_pc, ir_pc_plus4, ir_valid,
               misalign_err, range_err, retired_cnt
    );
endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection and alignment check; purely combinational.
module fetch_next_pc
    import rv32i_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  pc_sel_e     pc_sel,
    input  logic [31:0] pc_target,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc + 32'd4;
        case (pc_sel)
            PC_TGT:  next_pc = pc_target;
            // jalr drops bit 0 before the alignment check, so odd targets can still be legal
            PC_JALR: next_pc = pc_target & ~32'd1;
            default: next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = !is_word_aligned(next_pc);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, instruction register, fetch FSM and retire counter.
//
// state | meaning
// FETCH | PC drives ROM; capture word into ir when fetch_en, or trap out-of-range PC
// HOLD  | ir stable for decode/execute; pc_update retires and selects next PC
// FAULT | misaligned or out-of-range fetch; terminal until reset
module instr_fetch_unit
    import rv32i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned ROM_DEPTH = 256
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_unit_if.slave bus
);

    localparam logic [31:0] PC_LIMIT = 32'(ROM_DEPTH * 4);

    fetch_state_e state, state_nxt;

    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        misalign_err;
    logic        range_err;
    logic [31:0] retired_cnt;

    logic [31:0] next_pc;
    logic        next_misaligned;
    logic        pc_out_of_range;

    logic ir_load;
    logic pc_load;
    logic retire;
    logic set_misalign;
    logic set_range;
    logic drop_valid;

    fetch_next_pc u_next_pc (
        .pc         (pc),
        .pc_sel     (pc_sel_e'(bus.pc_sel)),
        .pc_target  (bus.pc_target),
        .next_pc    (next_pc),
        .misaligned (next_misaligned)
    );

    assign pc_out_of_range = pc >= PC_LIMIT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        retire       = 1'b0;
        set_misalign = 1'b0;
        set_range    = 1'b0;
        drop_valid   = 1'b0;
        case (state)
            FETCH: begin
                if (pc_out_of_range) begin
                    set_range = 1'b1;
                    state_nxt = FAULT;
                end else if (bus.fetch_en) begin
                    ir_load   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.pc_update) begin
                    // a faulting instruction still counts as retired
                    retire     = 1'b1;
                    drop_valid = 1'b1;
                    if (next_misaligned) begin
                        set_misalign = 1'b1;
                        state_nxt    = FAULT;
                    end else begin
                        pc_load   = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc           <= RESET_PC;
            ir           <= NOP_INSTR;
            ir_pc        <= RESET_PC;
            ir_valid     <= 1'b0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
            retired_cnt  <= 32'd0;
        end else begin
            if (ir_load) begin
                ir       <= bus.instr_data;
                ir_pc    <= pc;
                ir_valid <= 1'b1;
            end else if (drop_valid) begin
                ir_valid <= 1'b0;
            end
            if (pc_load) begin
                pc <= next_pc;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + 32'd1;
            end
            if (set_misalign) begin
                misalign_err <= 1'b1;
            end
            if (set_range) begin
                range_err <= 1'b1;
            end
        end
    end

    assign bus.instr_addr   = pc;
    assign bus.ir           = ir;
    assign bus.ir_pc        = ir_pc;
    assign bus.ir_pc_plus4  = ir_pc + 32'd4;
    assign bus.ir_valid     = ir_valid;
    assign bus.misalign_err = misalign_err;
    assign bus.range_err    = range_err;
    assign bus.retired_cnt  = retired_cnt;

endmodule
